// File: rtl/input_debouncer.sv
// ============================================================================
//  Module      : input_debouncer
//  Description : Synchronises a bouncy asynchronous input into clk and turns
//                it into a clean, registered level. A change is accepted only
//                after DEBOUNCE_CYCLES consecutive synchronised samples at the
//                new level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,     // asynchronous, active-low
    input  logic raw_in,
    output logic in_edge,
    output logic busy
);

    // Counter width is derived from the qualification length.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_CHECK_HI  = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_CHECK_LO  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             in_edge_q, in_edge_d;

    // Synchroniser chain: raw_in enters bit 0, the MSB is the only copy the
    // FSM is allowed to look at.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // State register: FSM state, qualification counter and the output level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STABLE_LO;
            cnt_q     <= CNT_ZERO;
            in_edge_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_edge_q <= in_edge_d;
        end
    end

    // Next-state logic: a candidate change must survive DEBOUNCE_CYCLES
    // consecutive samples; any sample back at the old level restarts it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_edge_d = in_edge_q;
        case (state_q)
            ST_STABLE_LO: begin
                if (sync_s) begin
                    state_d = ST_CHECK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_CHECK_HI: begin
                if (!sync_s) begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STABLE_HI;
                    in_edge_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE_HI: begin
                if (!sync_s) begin
                    state_d = ST_CHECK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_CHECK_LO: begin
                if (sync_s) begin
                    state_d = ST_STABLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STABLE_LO;
                    in_edge_d = 1'b0;
                    cnt_d     = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_STABLE_LO;
                cnt_d     = CNT_ZERO;
                in_edge_d = 1'b0;
            end
        endcase
    end

    // Output decode: busy comes only from registered state, so it cannot glitch.
    always_comb begin
        busy    = (state_q == ST_CHECK_HI) || (state_q == ST_CHECK_LO);
        in_edge = in_edge_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Directed bench for input_debouncer with a queue of expected
//                per-cycle output values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

    logic clk;
    logic reset;
    logic raw_in;
    logic in_edge;
    logic busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_trans  = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        string tag;
        logic  ie;
        logic  bz;
    } exp_t;

    exp_t sb[$];

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw_in),
        .in_edge(in_edge),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every movement of the debounced level seen downstream.
    always @(in_edge) begin
        if (mon_en) n_trans++;
    end

    task automatic check_now(input string tag, input logic ie, input logic bz);
        n_assert++;
        assert (in_edge === ie) else begin
            n_fail++;
            $error("FAIL %s in_edge: observed %b expected %b", tag, in_edge, ie);
        end
        n_assert++;
        assert (busy === bz) else begin
            n_fail++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, bz);
        end
    endtask

    // Drive one cycle of raw_in, queue what the outputs must be after the
    // next rising edge, then compare once that edge has passed.
    task automatic step(input string tag, input logic r, input logic ie, input logic bz);
        exp_t e;
        exp_t got;
        raw_in = r;
        e.tag = tag;
        e.ie  = ie;
        e.bz  = bz;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_now(got.tag, got.ie, got.bz);
    endtask

    // One character per cycle: raw_in level, expected in_edge, expected busy.
    task automatic run_seq(input string tag, input string raws,
                           input string ies, input string bzs);
        for (int i = 0; i < raws.len(); i++) begin
            step($sformatf("%s[e%0d]", tag, i + 1),
                 raws[i] == "1", ies[i] == "1", bzs[i] == "1");
        end
    endtask

    initial begin
        // 1: reset held with raw_in high; outputs stay low throughout.
        reset  = 1'b0;
        raw_in = 1'b1;
        #1;
        check_now("reset_async", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_now($sformatf("reset_hold%0d", i), 1'b0, 1'b0);
        end
        mon_en = 1'b1;
        reset  = 1'b1;
        run_seq("rel_hi",  "11111111", "00000111", "00111000");

        // 5: clean fall from a high level.
        run_seq("fall1",   "00000000", "11111000", "00111000");

        // 2: clean rise held ten cycles.
        run_seq("rise",    "1111111111", "0000011111", "0011100000");
        run_seq("fall2",   "00000000", "11111000", "00111000");

        // 3: three-cycle pulse; the drop lands on the last count and aborts.
        run_seq("glitch",  "11100000", "00000000", "00111000");

        // 4: bounce 1,0,1,1,1,... qualifies only on the 8th edge.
        run_seq("bounce",  "10111111", "00000001", "00101110");
        run_seq("fall3",   "00000000", "11111000", "00111000");

        // 6: reset while qualifying a rise with cnt=2.
        run_seq("pre_rst", "1111", "0000", "0011");
        #2;
        reset = 1'b0;
        #1;
        check_now("mid_reset", 1'b0, 1'b0);
        raw_in = 1'b0;
        @(posedge clk);
        #1;
        check_now("mid_reset_hold", 1'b0, 1'b0);
        reset = 1'b1;
        run_seq("post_rst", "000000", "000000", "000000");

        n_assert++;
        assert (n_trans === 6) else begin
            n_fail++;
            $error("FAIL transitions: observed %0d expected %0d", n_trans, 6);
        end
        n_assert++;
        assert (sb.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected %0d", sb.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
